ntt_addr_gen: RTL and testbench
===============================

// Module: ntt_addr_gen
// PURPOSE
// - Operand/twiddle sequencer directly upstream of the butterfly unit: walks all LOG_N layers of an
//   N-point in-place NTT (forward CT) or INTT (inverse GS) and issues one butterfly per cycle.
// - Per butterfly it issues: coefficient-RAM read addresses for a/b, twiddle ROM index and butterfly mode select.
// - Registered outputs feed the RAM/ROM read ports; read data lands on butterfly a_i/b_i/twiddle_i.
// PARAMETERS
// - LOG_N      8  log2 of transform size (N = 256)
// - LAYER_GAP  4  bubble cycles (valid_o=0) inserted between layers so butterfly write-back drains
// PORTS
// - clk_i            in   1      clock, rising edge
// - rst_n_i          in   1      asynchronous active-low reset
// - start_i          in   1      start request, sampled only in IDLE
// - inverse_i        in   1      0 = forward NTT, 1 = inverse NTT; latched on accepted start
// - stall_i          in   1      downstream not ready; freezes all sequencing and outputs
// - valid_o          out  1      addr/twiddle/sel outputs describe a butterfly this cycle
// - addr_a_o         out  LOG_N  read/write address of operand a
// - addr_b_o         out  LOG_N  read/write address of operand b (= addr_a_o + len)
// - twiddle_idx_o    out  LOG_N  twiddle ROM index k
// - sel_butterfly_o  out  1      butterfly mode for the butterfly sel_butterfly_i (= latched inverse)
// - last_o           out  1      valid_o is the final butterfly of the transform
// - busy_o           out  1      high from accepted start until done_o
// - done_o           out  1      single-cycle pulse one cycle after the last butterfly is issued
// BEHAVIOUR
// - Reset: state=IDLE; all outputs, layer counter and butterfly counter c = 0.
// - FSM: IDLE -(start_i)-> RUN; RUN -(c==N/2-1, layer<LOG_N-1, !stall)-> GAP;
//   GAP -(gap count == LAYER_GAP-1)-> RUN (layer+1, c=0); RUN -(last, !stall)-> DONE; DONE -> IDLE.
// - LAYER_GAP=0: GAP is skipped and the next layer starts directly.
// - Latency: valid_o rises in the cycle after start_i is sampled in IDLE.
// - Issue rate: one butterfly per cycle in RUN when stall_i=0.
// - Unstalled runtime: LOG_N*N/2 valid cycles + (LOG_N-1)*LAYER_GAP bubbles; 1052 cycles for the defaults.
// - Per layer L (0..LOG_N-1), c runs 0..N/2-1:
//   - Shift: s = LOG_N-1-L (forward) or s = L (inverse); len = 1<<s; group g = c>>s.
//   - addr_a = ((c>>s)<<(s+1)) | (c & (len-1)); addr_b = addr_a + len.
//   - Twiddle index: forward k = (1<<L) + g; inverse k = (N>>L) - 1 - g.
//     Twiddle negation for inverse belongs to the butterfly, not to this block.
// - Width rule: all address arithmetic is LOG_N bits, no wrap occurs; every result stays in 0..N-1.
// - stall_i=1: all registers hold, so outputs stay stable and valid_o keeps its value.
//   This includes the GAP counter and DONE; done_o is held until stall_i drops.
// - start_i while busy_o=1: ignored; inverse_i is not re-latched.
// - start_i in the DONE cycle: ignored; a new start is accepted only in IDLE.
// - last_o = valid_o && L==LOG_N-1 && c==N/2-1.
// - busy_o is high in RUN, GAP and DONE; done_o is high only in DONE.
// - rst_n_i low mid-transform: immediate return to reset values. No done_o, no residual valid_o.
// STRUCTURE
// - Shared package ntt_pkg: LOG_N/N constants, addr_t (logic [LOG_N-1:0]), state enum {IDLE,RUN,GAP,DONE}.
// - Optional sub-module ntt_index_map: combinational (L, c, inverse) -> (addr_a, addr_b, k).
//   Unit-testable against a software model.
// - Top holds the FSM, counters and output registers.
// TESTING
// - Forward, no stall:
//   - Pulse start_i with inverse_i=0. First valid_o has a=0, b=128, k=1.
//   - Layer 1 starts with a=0, b=64, k=2 after exactly 4 bubble cycles.
//   - Final beat is a=254, b=255, k=255 with last_o=1; done_o follows in the next cycle.
// - Inverse:
//   - First beat a=0, b=1, k=255, sel_butterfly_o=1.
//   - Layer 7 first beat a=0, b=128, k=1; final beat a=127, b=255, k=1.
// - Coverage: a software model checks all 1024 (a, b, k) tuples per direction.
//   - Each address appears exactly once per layer; exactly 1024 valid beats.
// - Stall: hold stall_i=1 for 3 cycles at forward beat c=5 of layer 0.
//   - Outputs stay a=5, b=133, k=1 throughout; the next beat is c=6 (a=6, b=134).
//   - Total runtime grows by exactly 3 cycles.
// - Start while busy: pulse start_i with inverse_i=1 mid layer 2 of a forward run.
//   - Sequence unchanged; sel_butterfly_o stays 0; only one done_o.
// - Async reset at layer 3: drop rst_n_i between clock edges.
//   - All outputs go to 0 immediately, without waiting for a clock edge.
//   - After release, a new start gives first beat a=0, b=128, k=1.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT operand/twiddle address sequencer.
package ntt_pkg;

    localparam int LOG_N         = 8;
    localparam int N             = 1 << LOG_N;
    localparam int HALF_N        = N / 2;
    localparam int LAYER_GAP_DEF = 4;
    localparam int LAYER_W       = $clog2(LOG_N);

    typedef logic [LOG_N-1:0]   addr_t;
    typedef logic [LOG_N-2:0]   cnt_t;
    typedef logic [LAYER_W-1:0] layer_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } state_t;

    localparam layer_t LAYER_LAST = layer_t'(LOG_N - 1);
    localparam cnt_t   CNT_LAST   = cnt_t'(HALF_N - 1);

endpackage

// File: rtl/ntt_index_map.sv
// Combinational map from (layer, butterfly counter, direction) to the
// operand addresses and twiddle ROM index of one in-place butterfly.
module ntt_index_map
    import ntt_pkg::*;
(
    input  layer_t layer,
    input  cnt_t   cnt,
    input  logic   inverse,
    output addr_t  addr_a,
    output addr_t  addr_b,
    output addr_t  twiddle_idx
);

    layer_t shift;
    addr_t  len;
    addr_t  c_ext;
    addr_t  grp;

    // Forward walks strides from N/2 down to 1, inverse from 1 up to N/2.
    // (N-1)>>L equals (N>>L)-1 and keeps the inverse index inside LOG_N bits.
    always_comb begin
        shift  = inverse ? layer : (LAYER_LAST - layer);
        len    = addr_t'(1) << shift;
        c_ext  = {1'b0, cnt};
        grp    = c_ext >> shift;
        addr_a = ((grp << shift) << 1) | (c_ext & (len - addr_t'(1)));
        addr_b = addr_a + len;
        if (inverse) begin
            twiddle_idx = (addr_t'(N - 1) >> layer) - grp;
        end else begin
            twiddle_idx = (addr_t'(1) << layer) + grp;
        end
    end

endmodule

// File: rtl/ntt_addr_gen.sv
// Layer/butterfly sequencer for an in-place N-point NTT (CT) or INTT (GS).
// Issues one butterfly per cycle with registered RAM/ROM addresses and
// inserts LAYER_GAP bubbles between layers for write-back to drain.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i
// RUN   | issuing butterfly (layer_q, cnt_q) on the outputs
// GAP   | bubble cycles between layers, gap_q counts them
// DONE  | one-cycle completion pulse, then back to IDLE
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int LAYER_GAP = LAYER_GAP_DEF
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  start_i,
    input  logic  inverse_i,
    input  logic  stall_i,
    output logic  valid_o,
    output addr_t addr_a_o,
    output addr_t addr_b_o,
    output addr_t twiddle_idx_o,
    output logic  sel_butterfly_o,
    output logic  last_o,
    output logic  busy_o,
    output logic  done_o
);

    localparam int GAP_W = (LAYER_GAP > 1) ? $clog2(LAYER_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((LAYER_GAP > 0) ? (LAYER_GAP - 1) : 0);

    state_t           state_q, state_nx;
    layer_t           layer_q, layer_nx;
    cnt_t             cnt_q, cnt_nx;
    logic [GAP_W-1:0] gap_q, gap_nx;
    logic             inv_q, inv_nx;
    logic             valid_nx;
    logic             last_nx;
    addr_t            map_a, map_b, map_k;

    // Addresses are computed for the butterfly that will be presented next,
    // so the output registers line up with the counters.
    ntt_index_map u_index_map (
        .layer       (layer_nx),
        .cnt         (cnt_nx),
        .inverse     (inv_nx),
        .addr_a      (map_a),
        .addr_b      (map_b),
        .twiddle_idx (map_k)
    );

    // Next-state and counter logic; stall gating is applied at the registers.
    always_comb begin
        state_nx = state_q;
        layer_nx = layer_q;
        cnt_nx   = cnt_q;
        gap_nx   = gap_q;
        inv_nx   = inv_q;
        valid_nx = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_nx = RUN;
                    layer_nx = '0;
                    cnt_nx   = '0;
                    inv_nx   = inverse_i;
                    valid_nx = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    if (layer_q == LAYER_LAST) begin
                        state_nx = DONE;
                    end else if (LAYER_GAP == 0) begin
                        layer_nx = layer_q + layer_t'(1);
                        cnt_nx   = '0;
                        valid_nx = 1'b1;
                    end else begin
                        state_nx = GAP;
                        gap_nx   = '0;
                    end
                end else begin
                    cnt_nx   = cnt_q + cnt_t'(1);
                    valid_nx = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_nx = RUN;
                    layer_nx = layer_q + layer_t'(1);
                    cnt_nx   = '0;
                    valid_nx = 1'b1;
                end else begin
                    gap_nx = gap_q + GAP_W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        last_nx = valid_nx && (layer_nx == LAYER_LAST) && (cnt_nx == CNT_LAST);
    end

    // State, counters and output registers; everything holds under stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            layer_q       <= '0;
            cnt_q         <= '0;
            gap_q         <= '0;
            inv_q         <= 1'b0;
            valid_o       <= 1'b0;
            last_o        <= 1'b0;
            addr_a_o      <= '0;
            addr_b_o      <= '0;
            twiddle_idx_o <= '0;
        end else if (!stall_i) begin
            state_q       <= state_nx;
            layer_q       <= layer_nx;
            cnt_q         <= cnt_nx;
            gap_q         <= gap_nx;
            inv_q         <= inv_nx;
            valid_o       <= valid_nx;
            last_o        <= last_nx;
            addr_a_o      <= valid_nx ? map_a : '0;
            addr_b_o      <= valid_nx ? map_b : '0;
            twiddle_idx_o <= valid_nx ? map_k : '0;
        end
    end

    assign sel_butterfly_o = inv_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Self-checking bench for ntt_addr_gen against a plain-arithmetic NTT index model.
module tb_ntt_addr_gen;

    localparam int LOGN   = 8;
    localparam int NPTS   = 256;
    localparam int HALF   = 128;
    localparam int BEATS  = LOGN * HALF;
    localparam int GAPS   = 4;
    localparam int RUNTIME = BEATS + (LOGN - 1) * GAPS;
    localparam int BUDGET = 4000;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       start_i;
    logic       inverse_i;
    logic       stall_i;
    logic       valid_o;
    logic [7:0] addr_a_o;
    logic [7:0] addr_b_o;
    logic [7:0] twiddle_idx_o;
    logic       sel_butterfly_o;
    logic       last_o;
    logic       busy_o;
    logic       done_o;

    int n_chk = 0;
    int n_err = 0;

    int exp_a [BEATS];
    int exp_b [BEATS];
    int exp_k [BEATS];
    int obs_a [BEATS];
    int obs_b [BEATS];
    int obs_k [BEATS];

    ntt_addr_gen dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .inverse_i       (inverse_i),
        .stall_i         (stall_i),
        .valid_o         (valid_o),
        .addr_a_o        (addr_a_o),
        .addr_b_o        (addr_b_o),
        .twiddle_idx_o   (twiddle_idx_o),
        .sel_butterfly_o (sel_butterfly_o),
        .last_o          (last_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference beat list straight from the stride/group definition of the transform.
    function automatic void build_model(input bit inv);
        for (int l = 0; l < LOGN; l++) begin
            for (int c = 0; c < HALF; c++) begin
                int s, len, g, idx;
                s   = inv ? l : (LOGN - 1 - l);
                len = 1 << s;
                g   = c / len;
                idx = l * HALF + c;
                exp_a[idx] = g * 2 * len + (c % len);
                exp_b[idx] = exp_a[idx] + len;
                exp_k[idx] = inv ? ((NPTS >> l) - 1 - g) : ((1 << l) + g);
            end
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, int'(valid_o), 0);
        chk({tag, "_a"}, int'(addr_a_o), 0);
        chk({tag, "_b"}, int'(addr_b_o), 0);
        chk({tag, "_k"}, int'(twiddle_idx_o), 0);
        chk({tag, "_sel"}, int'(sel_butterfly_o), 0);
        chk({tag, "_last"}, int'(last_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
    endtask

    // One transform. stall_beat/stall_len: directed stall once that beat is shown;
    // rand_stall: random stall cycles; busy_beat: start pulse with inverse=1 while busy;
    // abort_beat: return (without finishing) once that many beats were seen.
    task automatic run_transform(input bit inv, input int stall_beat, input int stall_len,
                                 input bit rand_stall, input int busy_beat, input int abort_beat);
        int  cyc, idx, nstall, bubbles, stall_left;
        bit  done_seen, stalled_prev, busy_sent;
        int  snap_v, snap_a, snap_b, snap_k, snap_l, snap_d;
        int  seen [LOGN][NPTS];
        int  bad;

        build_model(inv);
        @(negedge clk_i);
        start_i   = 1'b1;
        inverse_i = inv;
        stall_i   = 1'b0;
        @(negedge clk_i);
        start_i      = 1'b0;
        cyc          = 1;
        idx          = 0;
        nstall       = 0;
        bubbles      = 0;
        stall_left   = 0;
        done_seen    = 1'b0;
        stalled_prev = 1'b0;
        busy_sent    = 1'b0;
        snap_v = 0; snap_a = 0; snap_b = 0; snap_k = 0; snap_l = 0; snap_d = 0;

        while (!done_seen && cyc < BUDGET) begin
            if (stalled_prev) begin
                chk("hold_valid", int'(valid_o), snap_v);
                chk("hold_a", int'(addr_a_o), snap_a);
                chk("hold_b", int'(addr_b_o), snap_b);
                chk("hold_k", int'(twiddle_idx_o), snap_k);
                chk("hold_last", int'(last_o), snap_l);
                chk("hold_done", int'(done_o), snap_d);
            end else if (valid_o) begin
                if (idx < BEATS) begin
                    chk("beat_a", int'(addr_a_o), exp_a[idx]);
                    chk("beat_b", int'(addr_b_o), exp_b[idx]);
                    chk("beat_k", int'(twiddle_idx_o), exp_k[idx]);
                    chk("beat_sel", int'(sel_butterfly_o), int'(inv));
                    chk("beat_last", int'(last_o), (idx == BEATS - 1) ? 1 : 0);
                    if (idx > 0 && (idx % HALF) == 0) chk("layer_bubbles", bubbles, GAPS);
                    if (idx % HALF != 0) chk("no_bubble_in_layer", bubbles, 0);
                    obs_a[idx] = int'(addr_a_o);
                    obs_b[idx] = int'(addr_b_o);
                    obs_k[idx] = int'(twiddle_idx_o);
                end else begin
                    chk("extra_beat", idx, BEATS - 1);
                end
                bubbles = 0;
                if (idx == stall_beat) stall_left = stall_len;
                idx++;
            end else if (done_o) begin
                done_seen = 1'b1;
                chk("done_cycle", cyc, RUNTIME + 1 + nstall);
                chk("beat_count", idx, BEATS);
            end else begin
                bubbles++;
            end
            chk("busy_high", int'(busy_o), 1);

            if (abort_beat >= 0 && idx >= abort_beat) return;

            snap_v = int'(valid_o); snap_a = int'(addr_a_o); snap_b = int'(addr_b_o);
            snap_k = int'(twiddle_idx_o); snap_l = int'(last_o); snap_d = int'(done_o);

            start_i = 1'b0;
            if (!busy_sent && busy_beat >= 0 && idx >= busy_beat) begin
                start_i   = 1'b1;
                inverse_i = 1'b1;
                busy_sent = 1'b1;
            end
            stall_i = 1'b0;
            if (!done_seen) begin
                if (stall_left > 0) begin
                    stall_i = 1'b1;
                    stall_left--;
                end else if (rand_stall && $urandom_range(0, 7) == 0) begin
                    stall_i = 1'b1;
                end
            end
            if (stall_i) nstall++;
            stalled_prev = stall_i;
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        stall_i = 1'b0;

        if (!done_seen) begin
            chk("timeout_done", 0, 1);
            return;
        end

        @(negedge clk_i);
        chk("done_pulse_end", int'(done_o), 0);
        chk("idle_busy", int'(busy_o), 0);
        chk("idle_valid", int'(valid_o), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("no_second_done", int'(done_o) + int'(busy_o), 0);
        end

        for (int l = 0; l < LOGN; l++)
            for (int a = 0; a < NPTS; a++) seen[l][a] = 0;
        for (int i = 0; i < BEATS; i++) begin
            seen[i / HALF][obs_a[i]]++;
            seen[i / HALF][obs_b[i]]++;
        end
        bad = 0;
        for (int l = 0; l < LOGN; l++)
            for (int a = 0; a < NPTS; a++) if (seen[l][a] != 1) bad++;
        chk("addr_once_per_layer", bad, 0);

        if (!inv) begin
            chk("fwd_first_a", obs_a[0], 0);
            chk("fwd_first_b", obs_b[0], 128);
            chk("fwd_first_k", obs_k[0], 1);
            chk("fwd_l1_a", obs_a[HALF], 0);
            chk("fwd_l1_b", obs_b[HALF], 64);
            chk("fwd_l1_k", obs_k[HALF], 2);
            chk("fwd_last_a", obs_a[BEATS-1], 254);
            chk("fwd_last_b", obs_b[BEATS-1], 255);
            chk("fwd_last_k", obs_k[BEATS-1], 255);
        end else begin
            chk("inv_first_a", obs_a[0], 0);
            chk("inv_first_b", obs_b[0], 1);
            chk("inv_first_k", obs_k[0], 255);
            chk("inv_l7_a", obs_a[7*HALF], 0);
            chk("inv_l7_b", obs_b[7*HALF], 128);
            chk("inv_l7_k", obs_k[7*HALF], 1);
            chk("inv_last_a", obs_a[BEATS-1], 127);
            chk("inv_last_b", obs_b[BEATS-1], 255);
            chk("inv_last_k", obs_k[BEATS-1], 1);
        end
    endtask

    initial begin
        rst_n_i   = 1'b0;
        start_i   = 1'b0;
        inverse_i = 1'b0;
        stall_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_idle_outputs("post_reset");

        run_transform(1'b0, -1, 0, 1'b0, -1, -1);
        run_transform(1'b1, -1, 0, 1'b0, -1, -1);
        run_transform(1'b0, 5, 3, 1'b0, -1, -1);
        run_transform(1'b0, -1, 0, 1'b0, 2*HALF + 40, -1);
        run_transform(1'($urandom_range(0, 1)), -1, 0, 1'b1, -1, -1);
        run_transform(1'b1, -1, 0, 1'b1, -1, -1);

        run_transform(1'b0, -1, 0, 1'b0, -1, 3*HALF + 10);
        stall_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(negedge clk_i);
        check_idle_outputs("in_reset");
        rst_n_i = 1'b1;
        run_transform(1'b0, -1, 0, 1'b0, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
